// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mdu_pkg
// Description : Shared widths, op encodings and state types for the MIPS
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational multiply (shift-add) or restoring divide
//               (shift-subtract) iteration over a 2*WIDTH accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
    import mdu_pkg::*;
(
    input  mode_t              mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem;
    logic             w_ge;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}
        w_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: acc = {partial remainder, unconsumed dividend bits}
        w_trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        w_ge    = (w_trial >= {1'b0, opnd_i});
        w_sub   = w_trial[WIDTH-1:0] - opnd_i;
        w_rem   = w_ge ? w_sub : w_trial[WIDTH-1:0];

        if (mode_i == MODE_MUL) begin
            acc_o   = {w_sum, acc_i[WIDTH-1:1]};
            q_bit_o = 1'b0;
        end else begin
            // LSB is vacated here; the caller inserts q_bit_o
            acc_o   = {w_rem, acc_i[WIDTH-2:0], 1'b0};
            q_bit_o = w_ge;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : 33-cycle iterative MULT/MULTU/DIV/DIVU with HI/LO registers
//               and MTHI/MTLO write port.
// Config      : define MDU_SIGNED_EN for signed MULT/DIV; otherwise op[0]
//               is ignored and all ops are unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mode_t              mode_q, mode_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dzo_q, dzo_d;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_step_q;
    logic               w_b_zero;

    assign w_b_zero = (b_i == '0);

`ifdef MDU_SIGNED_EN
    logic w_signed;
    logic neg_res_q;
    logic neg_rem_q;

    assign w_signed = op_i[0];
    assign w_a_mag  = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag  = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    // Divide-by-zero keeps quotient all-ones, so its sign is never applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            neg_res_q <= w_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & ~(op_i[1] & w_b_zero);
            neg_rem_q <= w_signed & a_i[WIDTH-1];
        end
    end

    assign w_prod = neg_res_q ? -acc_q : acc_q;
    assign w_quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
    logic w_unused_op0;

    assign w_unused_op0 = op_i[0];
    assign w_a_mag      = a_i;
    assign w_b_mag      = b_i;
    assign w_prod       = acc_q;
    assign w_quo        = acc_q[WIDTH-1:0];
    assign w_rem        = acc_q[2*WIDTH-1:WIDTH];
`endif

    mdu_step u_step (
        .mode_i  (mode_q),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (w_step_acc),
        .q_bit_o (w_step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_MUL;
            acc_q   <= '0;
            opnd_q  <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_we_i) hi_d = wd_i;
                if (lo_we_i) lo_d = wd_i;
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    mode_d  = op_i[1] ? MODE_DIV : MODE_MUL;
                    dz_d    = op_i[1] & w_b_zero;
                    opnd_d  = op_i[1] ? w_b_mag : w_a_mag;
                    acc_d   = {{WIDTH{1'b0}}, (op_i[1] ? w_a_mag : w_b_mag)};
                end
            end
            ST_RUN: begin
                acc_d = {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                if (mode_q == MODE_DIV) begin
                    hi_d = w_rem;
                    lo_d = w_quo;
                end else begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dzo_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule
`default_nettype wire
